// File: rtl/bank_fifo_pkg.sv
// Shared types and constants for the bank-FIFO response path: tag type,
// merged response word and the per-cycle push acceptance helper.
package bank_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int BANK_NUM       = 4;

    typedef logic [0:0] master_id_t;

    localparam master_id_t MID_M0 = 1'b0;
    localparam master_id_t MID_M1 = 1'b1;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        master_id_t                id;
    } resp_word_t;

    // M0 takes the first free slot; M1 needs a slot left over after M0.
    function automatic logic [1:0] push_accept(input logic v0, input logic v1,
                                               input int unsigned free);
        logic [1:0] acc;
        acc    = 2'b00;
        acc[0] = v0 && (free >= 32'd1);
        acc[1] = v1 && (free >= (acc[0] ? 32'd2 : 32'd1));
        return acc;
    endfunction

endpackage

// File: rtl/resp_merger_dual_push_fifo.sv
// Circular buffer with two ordered write ports (a before b) and one read port.
// Port b is only used when port a also writes in the same cycle.
module dual_push_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wa_en_i,
    input  logic [WIDTH-1:0]         wa_data_i,
    input  logic                     wb_en_i,
    input  logic [WIDTH-1:0]         wb_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     not_empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             pop_s;
    logic             not_empty_s;

    // Next-state pointers and occupancy; pointers wrap by natural overflow.
    always_comb begin
        not_empty_s = (level_q != {LW{1'b0}});
        pop_s       = pop_i && not_empty_s;
        wr_ptr_d    = wr_ptr_q + PW'(wa_en_i) + PW'(wb_en_i);
        rd_ptr_d    = rd_ptr_q + PW'(pop_s);
        level_d     = level_q + LW'(wa_en_i) + LW'(wb_en_i) - LW'(pop_s);
    end

    // Pointer and level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage; contents are meaningless while level is 0, so no reset.
    always_ff @(posedge clk) begin
        if (wa_en_i) begin
            mem_q[wr_ptr_q] <= wa_data_i;
        end
        if (wb_en_i) begin
            mem_q[wr_ptr_q + PW'(1)] <= wb_data_i;
        end
    end

    // Head word is forced to zero when empty so stale storage never leaks out.
    always_comb begin
        if (not_empty_s) begin
            rd_data_o = mem_q[rd_ptr_q];
        end else begin
            rd_data_o = {WIDTH{1'b0}};
        end
        not_empty_o = not_empty_s;
        level_o     = level_q;
    end

endmodule

// File: rtl/resp_merger.sv
// Merges two non-backpressurable read-response streams into one tagged stream.
// Optional per-master accept counters are enabled by defining RESP_MERGER_CNT_EN.
module resp_merger #(
    parameter int DATA_WIDTH = bank_fifo_pkg::DEF_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_M0,
    input  logic [DATA_WIDTH-1:0]   data_out_M0,
    input  logic                    valid_M1,
    input  logic [DATA_WIDTH-1:0]   data_out_M1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH:0]     out_data,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
`ifdef RESP_MERGER_CNT_EN
    ,
    output logic [15:0]             cnt_M0,
    output logic [15:0]             cnt_M1
`endif
);

    import bank_fifo_pkg::*;

    logic                pop_s;
    int unsigned         free_s;
    logic [1:0]          acc_s;
    logic                wa_en_s, wb_en_s;
    logic [DATA_WIDTH:0] wa_data_s, wb_data_s;
    logic                drop_s;
    logic                overflow_q, overflow_d;

    // Arbitration: compact accepted words onto write ports a (first) and b.
    always_comb begin
        pop_s   = out_valid && out_ready;
        free_s  = 32'(DEPTH) - 32'(level) + 32'(pop_s);
        acc_s   = push_accept(valid_M0, valid_M1, free_s);
        wa_en_s = acc_s[0] | acc_s[1];
        wb_en_s = acc_s[0] & acc_s[1];
        if (acc_s[0]) begin
            wa_data_s = {data_out_M0, MID_M0};
        end else begin
            wa_data_s = {data_out_M1, MID_M1};
        end
        wb_data_s  = {data_out_M1, MID_M1};
        drop_s     = (valid_M0 & ~acc_s[0]) | (valid_M1 & ~acc_s[1]);
        overflow_d = overflow_q | drop_s;
    end

    dual_push_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wa_en_i     (wa_en_s),
        .wa_data_i   (wa_data_s),
        .wb_en_i     (wb_en_s),
        .wb_data_i   (wb_data_s),
        .pop_i       (pop_s),
        .rd_data_o   (out_data),
        .not_empty_o (out_valid),
        .level_o     (level)
    );

    // Sticky drop indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

`ifdef RESP_MERGER_CNT_EN
    logic [15:0] cnt_m0_q, cnt_m1_q;

    // Accepted-response counters, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_m0_q <= 16'd0;
            cnt_m1_q <= 16'd0;
        end else begin
            cnt_m0_q <= cnt_m0_q + 16'(acc_s[0]);
            cnt_m1_q <= cnt_m1_q + 16'(acc_s[1]);
        end
    end

    assign cnt_M0 = cnt_m0_q;
    assign cnt_M1 = cnt_m1_q;
`endif

endmodule

// File: tb/tb_resp_merger.sv
// Scoreboard bench for resp_merger: a queue model of the merge buffer is
// advanced with every driven cycle and compared against the DUT outputs.
`timescale 1ns/1ps
module tb_resp_merger;

    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_M0, valid_M1, out_ready;
    logic [7:0]  data_out_M0, data_out_M1;
    logic        out_valid, overflow;
    logic [8:0]  out_data;
    logic [4:0]  level;
`ifdef RESP_MERGER_CNT_EN
    logic [15:0] cnt_M0, cnt_M1;
    logic [15:0] m_cnt0, m_cnt1;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  mq[$];
    logic        m_ovf;

    resp_merger #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_M0    (valid_M0),
        .data_out_M0 (data_out_M0),
        .valid_M1    (valid_M1),
        .data_out_M1 (data_out_M1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .overflow    (overflow),
        .level       (level)
`ifdef RESP_MERGER_CNT_EN
        ,
        .cnt_M0      (cnt_M0),
        .cnt_M1      (cnt_M1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check_eq({tag, "_level"}, 32'(level), 32'(mq.size()));
        check_eq({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, "_data"}, 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
`ifdef RESP_MERGER_CNT_EN
        check_eq({tag, "_cnt0"}, 32'(cnt_M0), 32'(m_cnt0));
        check_eq({tag, "_cnt1"}, 32'(cnt_M1), 32'(m_cnt1));
`endif
    endtask

    // Drive one cycle, advance the model to the same edge, then compare.
    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                         input logic [7:0] d1, input logic rdy, input string tag);
        int free;
        valid_M0 = v0; data_out_M0 = d0;
        valid_M1 = v1; data_out_M1 = d1;
        out_ready = rdy;
        free = DEPTH - mq.size();
        if (rdy && mq.size() != 0) begin
            void'(mq.pop_front());
            free++;
        end
        if (v0) begin
            if (free > 0) begin
                mq.push_back({d0, 1'b0});
                free--;
`ifdef RESP_MERGER_CNT_EN
                m_cnt0++;
`endif
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (v1) begin
            if (free > 0) begin
                mq.push_back({d1, 1'b1});
                free--;
`ifdef RESP_MERGER_CNT_EN
                m_cnt1++;
`endif
            end else begin
                m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle_inputs();
        valid_M0 = 1'b0; valid_M1 = 1'b0; out_ready = 1'b0;
        data_out_M0 = 8'h00; data_out_M1 = 8'h00;
    endtask

    // Assert reset asynchronously (called just after a falling edge).
    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1'b1;
        #1;
        check_eq({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rst_level"}, 32'(level), 32'd0);
        check_eq({tag, "_rst_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_rst_data"}, 32'(out_data), 32'd0);
        mq.delete();
        m_ovf = 1'b0;
`ifdef RESP_MERGER_CNT_EN
        m_cnt0 = 16'd0; m_cnt1 = 16'd0;
`endif
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_rst_hold_level"}, 32'(level), 32'd0);
        rst = 1'b0;
        check_state({tag, "_post"});
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_ovf = 1'b0;
`ifdef RESP_MERGER_CNT_EN
        m_cnt0 = 16'd0; m_cnt1 = 16'd0;
`endif
        @(negedge clk);
        do_reset("init");

        // Single M0 push, not drained.
        drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, "single");
        check_eq("single_lit_data", 32'(out_data), 32'h14A);
        check_eq("single_lit_level", 32'(level), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "single_drain");

        // Both masters in one cycle: M0 first, then M1.
        drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, "both");
        check_eq("both_lit_first", 32'(out_data), 32'h022);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "both_pop1");
        check_eq("both_lit_second", 32'(out_data), 32'h045);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "both_pop2");
        check_eq("both_lit_empty", 32'(level), 32'd0);

        // Fill completely, then an M1 word must be dropped.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i + 8'h40), 1'b0, 8'h00, 1'b0, "fill");
        check_eq("fill_no_ovf", 32'(overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 8'hEE, 1'b0, "full_drop");
        check_eq("full_lit_level", 32'(level), 32'd16);
        check_eq("full_lit_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check_eq("full_tag_m0", 32'(out_data[0]), 32'd0);
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "full_drain");
        end
        check_eq("full_drained", 32'(out_valid), 32'd0);

        // Reset with 7 entries buffered and overflow set.
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, "pre_rst");
        check_eq("pre_rst_level", 32'(level), 32'd7);
        do_reset("mid");
        drive(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, "after_rst");
        check_eq("after_rst_lit_valid", 32'(out_valid), 32'd1);
        check_eq("after_rst_lit_data", 32'(out_data), 32'h079);

        // One free slot, both valid, no pop: M1 dropped.
        do_reset("l15a");
        for (int i = 0; i < 15; i++) drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, "l15a_fill");
        drive(1'b1, 8'hC0, 1'b1, 8'hC1, 1'b0, "l15a_both");
        check_eq("l15a_lit_level", 32'(level), 32'd16);
        check_eq("l15a_lit_ovf", 32'(overflow), 32'd1);

        // One free slot plus a pop: both accepted.
        do_reset("l15b");
        for (int i = 0; i < 15; i++) drive(1'b1, 8'(i), 1'b0, 8'h00, 1'b0, "l15b_fill");
        drive(1'b1, 8'hD0, 1'b1, 8'hD1, 1'b1, "l15b_both");
        check_eq("l15b_lit_level", 32'(level), 32'd16);
        check_eq("l15b_lit_ovf", 32'(overflow), 32'd0);

        // Random traffic with phases of varying drain rate.
        do_reset("rnd");
        for (int c = 0; c < 10000; c++) begin
            int thr;
            case ((c / 500) % 4)
                0: thr = 90;
                1: thr = 40;
                2: thr = 10;
                default: thr = 70;
            endcase
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  8'($urandom), 1'($urandom_range(0, 99) < thr), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
